// File: rtl/mcont_buf_wr_seq.sv
// Buffer-write sequencer: a read-burst descriptor plus the PHY read-data stream become
// buffer-write bus cycles. The optional idle timeout is enabled by MCONT_BUF_WR_TIMEOUT_EN.
module mcont_buf_wr_seq #(
    parameter int ADDR_WIDTH     = 7,
    parameter int CHN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CHN_WIDTH-1:0]  start_chn,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] start_nwords,
    input  logic                  rd_valid,
    input  logic [63:0]           rd_data,
    output logic                  ext_buf_wr,
    output logic [ADDR_WIDTH-1:0] ext_buf_waddr,
    output logic [CHN_WIDTH-1:0]  ext_buf_wchn,
    output logic [63:0]           ext_buf_wdata,
    output logic                  seq_done,
    output logic                  busy,
    output logic                  start_ign,
    output logic                  stray
`ifdef MCONT_BUF_WR_TIMEOUT_EN
    ,
    output logic                  timeout_err
`endif
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]        rem_q, rem_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [63:0]             wdata_q, wdata_d;
    logic [CHN_WIDTH-1:0]    wchn_q, wchn_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    ign_q, ign_d;
    logic                    stray_q, stray_d;

`ifdef MCONT_BUF_WR_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    // The counter is one behind the gap length, so DONE (and seq_done) lands
    // TIMEOUT_CYCLES cycles after the last accepted word or start.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]         idle_q, idle_d;
    logic                    to_q, to_d;
`endif

    // Next-state, counters and write-bus decode
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wr_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wchn_d  = wchn_q;
        ign_d   = 1'b0;
        stray_d = 1'b0;
`ifdef MCONT_BUF_WR_TIMEOUT_EN
        idle_d  = idle_q;
        to_d    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_XFER;
                    wchn_d  = start_chn;
                    addr_d  = start_addr;
                    rem_d   = (start_nwords == '0) ? FULL_CNT : {1'b0, start_nwords};
`ifdef MCONT_BUF_WR_TIMEOUT_EN
                    idle_d  = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                end else begin
`ifdef MCONT_BUF_WR_TIMEOUT_EN
                    if (rd_valid) begin
                        idle_d  = '0;
                        state_d = ST_XFER;
                    end else begin
                        idle_d = idle_q + TO_W'(1);
                        if (idle_d == TO_LAST) begin
                            state_d = ST_DONE;
                            to_d    = 1'b1;
                        end else begin
                            state_d = ST_XFER;
                        end
                    end
`else
                    state_d = ST_XFER;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Data is taken only while words remain; anything else on rd_valid is stray
        if ((state_q == ST_XFER) && (rem_q != '0) && rd_valid) begin
            wr_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = rd_data;
            addr_d  = addr_q + ADDR_WIDTH'(1);
            rem_d   = rem_q - CNT_W'(1);
        end else if (rd_valid) begin
            stray_d = 1'b1;
        end else begin
            stray_d = 1'b0;
        end

        if (start && (state_q != ST_IDLE)) begin
            ign_d = 1'b1;
        end else begin
            ign_d = 1'b0;
        end

        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any burst without seq_done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            wr_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 64'd0;
            wchn_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ign_q   <= 1'b0;
            stray_q <= 1'b0;
`ifdef MCONT_BUF_WR_TIMEOUT_EN
            idle_q  <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wr_q    <= wr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wchn_q  <= wchn_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ign_q   <= ign_d;
            stray_q <= stray_d;
`ifdef MCONT_BUF_WR_TIMEOUT_EN
            idle_q  <= idle_d;
            to_q    <= to_d;
`endif
        end
    end

    assign ext_buf_wr    = wr_q;
    assign ext_buf_waddr = waddr_q;
    assign ext_buf_wchn  = wchn_q;
    assign ext_buf_wdata = wdata_q;
    assign seq_done      = done_q;
    assign busy          = busy_q;
    assign start_ign     = ign_q;
    assign stray         = stray_q;
`ifdef MCONT_BUF_WR_TIMEOUT_EN
    assign timeout_err   = to_q;
`endif

endmodule
